// File: rtl/sce_axibuf_pkg.sv
// Shared types and helpers for the SCE AXI write buffer.
//   aw_entry_t : one queued AW request {id,addr,size,prot,len,burst}
//   w_entry_t  : one buffered W beat {data,strb,last}
//   ptr_w()    : pointer width for a power-of-2 FIFO depth
package sce_axibuf_pkg;

   localparam int SCE_AW  = 32;
   localparam int SCE_DW  = 32;
   localparam int SCE_IDW = 5;

   typedef struct packed {
      logic [SCE_IDW-1:0] id;
      logic [SCE_AW-1:0]  addr;
      logic [2:0]         size;
      logic [2:0]         prot;
      logic [7:0]         len;
      logic [1:0]         burst;
   } aw_entry_t;

   typedef struct packed {
      logic [SCE_DW-1:0]   data;
      logic [SCE_DW/8-1:0] strb;
      logic                last;
   } w_entry_t;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/sce_axibuf_fifo.sv
// Generic synchronous FIFO with a parameterised entry type.
// Ports: clk, reset (sync, active-high), push/din, pop/dout,
//        full, empty, count (occupancy, one bit wider than the pointers).
// Push while full and pop while empty are ignored.
module sce_axibuf_fifo
   import sce_axibuf_pkg::*;
#(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  T                        din,
   input  logic                    pop,
   output T                        dout,
   output logic                    full,
   output logic                    empty,
   output logic [ptr_w(DEPTH):0]   count
);

   localparam int            PW       = ptr_w(DEPTH);
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   T                mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/sce_axi_wrbuf.sv
// Store-and-forward AXI write buffer between an SCE master write port and
// the system fabric. AW requests and W beats are queued locally; a
// downstream AW is released once its whole burst is buffered, or early
// (cut-through) when the W FIFO is full of that burst alone. B passes through.
// Ports: clk, reset (sync, active-high); s_aw*/s_w*/s_b* upstream slave side;
//        m_aw*/m_w*/m_b* downstream master side; lenerr (sticky wlast vs
//        awlen disagreement); busy (anything queued or buffered).
module sce_axi_wrbuf
   import sce_axibuf_pkg::*;
#(
   parameter int AW    = SCE_AW,
   parameter int DW    = SCE_DW,
   parameter int IDW   = SCE_IDW,
   parameter int DEPTH = 16,
   parameter int AQ    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [IDW-1:0]  s_awid,
   input  logic [AW-1:0]   s_awaddr,
   input  logic [2:0]      s_awsize,
   input  logic [2:0]      s_awprot,
   input  logic [7:0]      s_awlen,
   input  logic [1:0]      s_awburst,
   input  logic            s_wvalid,
   output logic            s_wready,
   input  logic [DW-1:0]   s_wdata,
   input  logic [DW/8-1:0] s_wstrb,
   input  logic            s_wlast,
   output logic            s_bvalid,
   input  logic            s_bready,
   output logic [1:0]      s_bresp,
   output logic [IDW-1:0]  s_bid,
   output logic            m_awvalid,
   input  logic            m_awready,
   output logic [IDW-1:0]  m_awid,
   output logic [AW-1:0]   m_awaddr,
   output logic [2:0]      m_awsize,
   output logic [2:0]      m_awprot,
   output logic [7:0]      m_awlen,
   output logic [1:0]      m_awburst,
   output logic            m_wvalid,
   input  logic            m_wready,
   output logic [DW-1:0]   m_wdata,
   output logic [DW/8-1:0] m_wstrb,
   output logic            m_wlast,
   input  logic            m_bvalid,
   output logic            m_bready,
   input  logic [1:0]      m_bresp,
   input  logic [IDW-1:0]  m_bid,
   output logic            lenerr,
   output logic            busy
);

   // Burst counters are one bit wider than the AW queue index so that
   // "queue full" and "queue empty" are distinguishable as modular differences.
   localparam int CW = ptr_w(AQ) + 1;

   aw_entry_t                aw_in, aw_head;
   w_entry_t                 w_in, w_head;
   logic                     aq_full, aq_empty, wf_full, wf_empty;
   logic [ptr_w(AQ):0]       aq_count;
   logic [ptr_w(DEPTH):0]    wf_count;

   logic [CW-1:0]  aw_rcvd, bursts_rcvd, aw_issued, bursts_drained;
   logic [CW-1:0]  rcv_pending, head_ahead, drain_pending;
   logic [8:0]     bcnt;
   logic [7:0]     cur_len;
   logic           aw_push, w_push, aw_pop, w_pop;
   logic           at_len, w_close, head_done, cut_through;

   // Burst lengths indexed by burst number. A cut-through burst leaves the AW
   // queue before it is fully received, so its length cannot be read from the
   // queue; the window of live burst numbers is at most AQ+1, hence 2*AQ slots.
   logic [7:0]     len_mem [2*AQ];

   assign aw_push = s_awvalid && s_awready;
   assign w_push  = s_wvalid && s_wready;
   assign aw_pop  = m_awvalid && m_awready;
   assign w_pop   = m_wvalid && m_wready;

   assign rcv_pending   = aw_rcvd - bursts_rcvd;
   assign head_ahead    = bursts_rcvd - aw_issued;
   assign drain_pending = aw_issued - bursts_drained;

   assign cur_len = len_mem[bursts_rcvd];
   assign at_len  = (bcnt == {1'b0, cur_len});
   assign w_close = s_wlast || at_len;

   // head_ahead wraps to all-ones when a cut-through head was issued ahead of
   // reception, so "complete" means a difference in 1..AQ.
   assign head_done   = (head_ahead != '0) && (head_ahead <= CW'(AQ));
   // Early release only when the full FIFO holds nothing but the head burst.
   assign cut_through = wf_full && (head_ahead == '0) && (drain_pending == '0);

   assign s_awready = !reset && !aq_full;
   assign s_wready  = !reset && !wf_full && (rcv_pending != '0);
   assign m_awvalid = !reset && !aq_empty && (head_done || cut_through);
   assign m_wvalid  = !reset && !wf_empty && (drain_pending != '0);

   assign aw_in = '{id: s_awid, addr: s_awaddr, size: s_awsize, prot: s_awprot,
                    len: s_awlen, burst: s_awburst};
   assign w_in  = '{data: s_wdata, strb: s_wstrb, last: w_close};

   sce_axibuf_fifo #(.T(aw_entry_t), .DEPTH(AQ)) u_aq (
      .clk   (clk),
      .reset (reset),
      .push  (aw_push),
      .din   (aw_in),
      .pop   (aw_pop),
      .dout  (aw_head),
      .full  (aq_full),
      .empty (aq_empty),
      .count (aq_count)
   );

   sce_axibuf_fifo #(.T(w_entry_t), .DEPTH(DEPTH)) u_wf (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (w_in),
      .pop   (w_pop),
      .dout  (w_head),
      .full  (wf_full),
      .empty (wf_empty),
      .count (wf_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_rcvd        <= '0;
         bursts_rcvd    <= '0;
         aw_issued      <= '0;
         bursts_drained <= '0;
         bcnt           <= '0;
         lenerr         <= 1'b0;
      end else begin
         if (aw_push) aw_rcvd <= aw_rcvd + CW'(1);
         if (w_push) begin
            if (w_close) begin
               bcnt        <= '0;
               bursts_rcvd <= bursts_rcvd + CW'(1);
            end else begin
               bcnt <= bcnt + 9'd1;
            end
            if (s_wlast != at_len) lenerr <= 1'b1;
         end
         if (aw_pop) aw_issued <= aw_issued + CW'(1);
         if (w_pop && w_head.last) bursts_drained <= bursts_drained + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (aw_push) len_mem[aw_rcvd] <= s_awlen;
   end

   assign m_awid    = aw_head.id;
   assign m_awaddr  = aw_head.addr;
   assign m_awsize  = aw_head.size;
   assign m_awprot  = aw_head.prot;
   assign m_awlen   = aw_head.len;
   assign m_awburst = aw_head.burst;

   assign m_wdata = w_head.data;
   assign m_wstrb = w_head.strb;
   assign m_wlast = w_head.last;

   assign s_bvalid = m_bvalid;
   assign m_bready = s_bready;
   assign s_bresp  = m_bresp;
   assign s_bid    = m_bid;

   assign busy = (aq_count != '0) || (wf_count != '0);

endmodule
